// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller: main street A, side street B, ped WALK.
// Moore FSM; lamps decode straight from the state register.
module traffic_intersection_ctrl #(
  parameter int T_GREEN_A = 8,
  parameter int T_GREEN_B = 6,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 1,
  parameter int T_WALK    = 5,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_b,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_yellow,
  output logic       a_green,
  output logic       b_red,
  output logic       b_yellow,
  output logic       b_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    A_GREEN    = 3'd0,
    A_YELLOW   = 3'd1,
    ALL_RED_AB = 3'd2,
    B_GREEN    = 3'd3,
    B_YELLOW   = 3'd4,
    ALL_RED_BA = 3'd5,
    PED_WALK   = 3'd6
  } phase_t;

  localparam logic [CNT_W-1:0] GA_END = CNT_W'(T_GREEN_A - 1);
  localparam logic [CNT_W-1:0] GB_END = CNT_W'(T_GREEN_B - 1);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] R_END  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] W_END  = CNT_W'(T_WALK - 1);

  phase_t           cur;
  phase_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             ga_met;
  logic             enter_walk;

  // Code 7 passes through the cast and falls into the default arms.
  assign cur        = phase_t'(state);
  assign ga_met     = (cnt >= GA_END);
  assign enter_walk = (nxt == PED_WALK) && (cur != PED_WALK);

  always_comb begin
    nxt = cur;
    case (cur)
      A_GREEN:
        if (ga_met && (car_b || ped_pending)) nxt = A_YELLOW;
      A_YELLOW:
        if (cnt == Y_END) nxt = ALL_RED_AB;
      ALL_RED_AB:
        if (cnt == R_END) nxt = ped_pending ? PED_WALK : B_GREEN;
      B_GREEN:
        if (cnt == GB_END) nxt = B_YELLOW;
      B_YELLOW:
        if (cnt == Y_END) nxt = ALL_RED_BA;
      PED_WALK:
        if (cnt == W_END) nxt = ALL_RED_BA;
      ALL_RED_BA:
        if (cnt == R_END) nxt = A_GREEN;
      default:
        nxt = ALL_RED_BA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= A_GREEN;
      cnt         <= '0;
      ped_pending <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != cur)
        cnt <= '0;
      else if (cur == A_GREEN && ga_met)
        cnt <= cnt;
      else
        cnt <= cnt + 1'b1;
      // A new press on the clearing edge is kept for the next round.
      ped_pending <= ped_req | (ped_pending & ~enter_walk);
    end
  end

  always_comb begin
    a_red    = 1'b1;
    a_yellow = 1'b0;
    a_green  = 1'b0;
    b_red    = 1'b1;
    b_yellow = 1'b0;
    b_green  = 1'b0;
    walk     = 1'b0;
    case (cur)
      A_GREEN: begin
        a_red   = 1'b0;
        a_green = 1'b1;
      end
      A_YELLOW: begin
        a_red    = 1'b0;
        a_yellow = 1'b1;
      end
      B_GREEN: begin
        b_red   = 1'b0;
        b_green = 1'b1;
      end
      B_YELLOW: begin
        b_red    = 1'b0;
        b_yellow = 1'b1;
      end
      PED_WALK: walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios plus random
// traffic, all checked each cycle against a phase/age reference model.
module tb_traffic_intersection_ctrl;

  localparam int TGA = 8;
  localparam int TGB = 6;
  localparam int TY  = 3;
  localparam int TR  = 1;
  localparam int TW  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car_b = 1'b0;
  logic       ped_req = 1'b0;
  logic       a_red, a_yellow, a_green;
  logic       b_red, b_yellow, b_green;
  logic       walk, ped_pending;
  logic [2:0] state;
  logic [6:0] lamps;

  int   n_chk = 0;
  int   n_pass = 0;
  int   m_ph = 0;
  int   m_age = 0;
  logic m_ped = 1'b0;
  logic inj = 1'b0;

  traffic_intersection_ctrl dut (
    .clk(clk), .rst_n(rst_n), .car_b(car_b), .ped_req(ped_req),
    .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
    .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
    .walk(walk), .ped_pending(ped_pending), .state(state)
  );

  assign lamps = {a_red, a_yellow, a_green,
                  b_red, b_yellow, b_green, walk};

  always #5 clk = ~clk;

  function automatic int dwell_of(int p);
    case (p)
      0:       return TGA;
      1, 4:    return TY;
      2, 5:    return TR;
      3:       return TGB;
      6:       return TW;
      default: return 1;
    endcase
  endfunction

  function automatic int after(int p, logic ped);
    case (p)
      0:       return 1;
      1:       return 2;
      2:       return ped ? 6 : 3;
      3:       return 4;
      4:       return 5;
      6:       return 5;
      5:       return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int cur_ph();
    return inj ? 7 : m_ph;
  endfunction

  function automatic int next_ph();
    int p;
    p = cur_ph();
    if (p == 0)
      return (m_age >= TGA - 1 && (car_b || m_ped)) ? 1 : 0;
    if (p > 6) return 5;
    return (m_age >= dwell_of(p) - 1) ? after(p, m_ped) : p;
  endfunction

  function automatic logic [6:0] exp_lamps(int p);
    logic ag, ay, bg, by;
    ag = (p == 0);
    ay = (p == 1);
    bg = (p == 3);
    by = (p == 4);
    return {!(ag || ay), ay, ag, !(bg || by), by, bg, p == 6};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph  <= 0;
      m_age <= 0;
      m_ped <= 1'b0;
    end else begin
      m_ph  <= next_ph();
      m_age <= (next_ph() != cur_ph()) ? 0 : m_age + 1;
      m_ped <= ped_req |
               (m_ped & !(next_ph() == 6 && cur_ph() != 6));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inj = 1'b0;
    chk("state", 32'(state), cur_ph());
    chk("lamps", 32'(lamps), 32'(exp_lamps(cur_ph())));
    chk("ped", 32'(ped_pending), 32'(m_ped));
    chk("onehot", {30'd0, $onehot({a_red, a_yellow, a_green}),
                   $onehot({b_red, b_yellow, b_green})}, 32'd3);
  endtask

  task automatic wait_state(input int code, input int limit,
                            input string tag);
    int k;
    k = 0;
    while (state != 3'(code) && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 32'(state), code);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int per, t0, nwalk, nag, nb, t6, t3;
    logic [2:0] prev;

    // idle hold
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("idle_state", 32'(state), 0);
    chk("idle_ped", 32'(ped_pending), 0);

    // side-street demand, 22-cycle period
    car_b = 1'b1;
    do_reset();
    per = 0;
    t0 = -1;
    prev = state;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (state == 3'd1 && prev != 3'd1) begin
        if (t0 >= 0) per = i - t0;
        t0 = i;
      end
      prev = state;
    end
    chk("period", per, 22);
    car_b = 1'b0;

    // pedestrian request
    do_reset();
    repeat (2) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_set", 32'(ped_pending), 1);
    nwalk = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (walk) nwalk++;
    end
    chk("walk_len", nwalk, 5);

    // late demand
    do_reset();
    nag = 1;
    repeat (20) begin
      tick();
      if (state == 3'd0) nag++;
    end
    car_b = 1'b1;
    tick();
    car_b = 1'b0;
    chk("late_yel", 32'(state), 1);
    chk("late_ag_len", nag, 21);
    nb = 0;
    repeat (20) begin
      tick();
      if (state == 3'd3) nb++;
    end
    chk("late_b_len", nb, 6);

    // request during WALK, ped beats car_b
    car_b = 1'b1;
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    wait_state(6, 40, "reach_walk");
    repeat (2) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    t6 = -1;
    t3 = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state == 3'd6 && t6 < 0) t6 = i;
      if (state == 3'd3 && t3 < 0) t3 = i;
    end
    chk("ped_before_b", 32'(t6 >= 0 && (t3 < 0 || t6 < t3)), 1);

    // reset mid B_GREEN with a pending request
    do_reset();
    wait_state(3, 40, "reach_bg");
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    chk("mid_ped", 32'(ped_pending), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_ped", 32'(ped_pending), 0);
    chk("mid_rst_lamps", 32'(lamps), 32'(7'b0011000));
    car_b = 1'b0;

    // illegal code inject
    repeat (3) tick();
    force dut.state = 3'd7;
    #1;
    release dut.state;
    inj = 1'b1;
    chk("ill_state", 32'(state), 7);
    chk("ill_lamps", 32'(lamps), 32'(7'b1001000));
    tick();
    chk("ill_next", 32'(state), 5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) car_b = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 24) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Two-way intersection controller that sequences the main-street (A) and side-street (B) signal heads plus a pedestrian WALK phase. It is built on the same Moore-FSM style as the single-head semaphore. The block owns the conflict-free phase schedule: A holds green by default, and B gets green on side-street demand or a latched pedestrian request. It sits between sensor/button inputs and the lamp drivers of both heads.

## Interface
- T_GREEN_A, 8: minimum A green dwell, cycles
- T_GREEN_B, 6: fixed B green dwell, cycles
- T_YELLOW, 3: yellow dwell for either head, cycles
- T_ALLRED, 1: all-red clearance dwell, cycles
- T_WALK, 5: pedestrian WALK dwell, cycles
- CNT_W, 8: dwell counter width; every T_* must be in 1..2^CNT_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; **synchronous, active-low**
- car_b  in  1  side-street vehicle present (level)
- ped_req  in  1  pedestrian button (≥1-cycle pulse)
- a_red, a_yellow, a_green  out  1 each  A head lamps
- b_red, b_yellow, b_green  out  1 each  B head lamps
- walk  out  1  pedestrian WALK lamp
- ped_pending  out  1  latched, unserved pedestrian request
- state  out  3  current phase code

## Operation
- State codes:
  - A_GREEN = 0
  - A_YELLOW = 1
  - ALL_RED_AB = 2
  - B_GREEN = 3
  - B_YELLOW = 4
  - ALL_RED_BA = 5
  - PED_WALK = 6
  - code 7 is illegal.
- Outputs are a Moore decode of the state register; exactly one lamp per head is on.
  - A_GREEN: a_green, b_red.
  - A_YELLOW: a_yellow, b_red.
  - B_GREEN: a_red, b_green.
  - B_YELLOW: a_red, b_yellow.
  - ALL_RED_AB, ALL_RED_BA, PED_WALK: a_red, b_red.
  - walk=1 only in PED_WALK.
- Dwell counter cnt:
  - cleared to 0 on every state change;
  - increments each cycle otherwise;
  - in A_GREEN, saturates at T_GREEN_A-1.
- Transitions, evaluated at the rising edge:
  - A_GREEN -> A_YELLOW when cnt ≥ T_GREEN_A-1 and (car_b | ped_pending); otherwise hold indefinitely.
  - A_YELLOW -> ALL_RED_AB when cnt == T_YELLOW-1.
  - ALL_RED_AB -> PED_WALK if ped_pending, else B_GREEN, when cnt == T_ALLRED-1.
  - B_GREEN -> B_YELLOW when cnt == T_GREEN_B-1. car_b is ignored during B_GREEN.
  - B_YELLOW -> ALL_RED_BA when cnt == T_YELLOW-1.
  - PED_WALK -> ALL_RED_BA when cnt == T_WALK-1.
  - ALL_RED_BA -> A_GREEN when cnt == T_ALLRED-1.
  - Illegal code 7 -> ALL_RED_BA on the next edge; outputs decode to all red, walk=0.
- ped_pending:
  - set by ped_req=1 at any edge;
  - cleared at the edge entering PED_WALK.
  - If ped_req=1 coincides with the clearing edge, set wins; the request is served in the next cycle round.
- Priority when car_b and ped_pending are both true at ALL_RED_AB exit: PED_WALK wins. B is not served in that round; A_GREEN then re-requests on car_b after its minimum dwell.
- No phase sequence allows green/yellow on both heads, or walk with any non-red lamp.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - state=A_GREEN, cnt=0, ped_pending=0;
  - hence a_green=1, b_red=1, all other lamps 0, walk=0.
  - Reset takes effect at the edge, from any state, including mid-phase.
- A phase with dwell T occupies exactly T consecutive cycles of state.
- ped_req to ped_pending: 1 cycle.
- car_b/ped_pending effect in A_GREEN (once the minimum dwell is met): A_YELLOW appears in the cycle after the sampling edge.
- Full cycle with car_b held high at the defaults: 8+3+1+6+3+1 = 22 cycles.
- Outputs change in the same cycle as state; there is no extra output register.

## Test plan
- **Idle hold:** rst_n=0 for 3 cycles, then 40 cycles with car_b=0 and ped_req=0. Required: state=0 throughout, a_green=1, b_red=1, walk=0, ped_pending=0.
- **Side-street demand:** car_b=1 held from reset release. Required dwells: A_GREEN 8, A_YELLOW 3, ALL_RED_AB 1, B_GREEN 6, B_YELLOW 3, ALL_RED_BA 1, repeating every 22 cycles; lamp one-hot per head in every cycle.
- **Pedestrian request:** one-cycle ped_req 2 cycles after reset release, car_b=0. Required:
  - ped_pending=1 from the next cycle;
  - sequence A_GREEN (8) -> A_YELLOW (3) -> ALL_RED_AB (1) -> PED_WALK (5, walk=1, ped_pending=0) -> ALL_RED_BA (1) -> A_GREEN.
- **Late demand:** A_GREEN held 20 cycles, then car_b=1 for a single cycle. Required: A_YELLOW in the next cycle, A_GREEN dwell 21, and a full B phase (6 cycles) even though car_b has dropped.
- **Request during WALK, and both-demand priority:**
  - ped_req pulse in PED_WALK cycle 3. Required: ped_pending=1 stays through ALL_RED_BA; A_GREEN for 8 cycles, then a second PED_WALK.
  - With car_b=1 also held, PED_WALK precedes B_GREEN.
- **Reset mid-operation:** rst_n=0 for 1 cycle in B_GREEN cycle 3 while ped_pending=1. Required: next cycle state=0, a_green=1, b_red=1, ped_pending=0. Also force state=7 with an X/illegal inject and check the next cycle is ALL_RED_BA, all red.
